// File: rtl/fmap_streamer.sv
// Streams a stored ROWS x COLS feature map to a pooling stage in row-major order.
// Rows are separated by GAP idle cycles, and the frame ends with one tail cycle and a done pulse.
module fmap_streamer #(
  parameter int DW   = 16,
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int GAP  = 2,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          load,
  output logic [DW-1:0] conv_out,
  output logic          out_valid,
  output logic [AW-1:0] row_idx,
  output logic [AW-1:0] col_idx,
  output logic          done
);

  localparam int DEPTH = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_TAIL} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic [DW-1:0] conv_q, conv_d;
  logic [3:0]    gap_q, gap_d;
  logic          valid_q, valid_d, load_q, load_d, busy_q, busy_d, done_q, done_d;
  logic          fetch;
  logic          wr_ok;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] mem_q [DEPTH];

  assign wr_ok = wr_en && !busy_q && (int'(wr_addr) < DEPTH);

  // NOTE: the frame buffer has no reset so it maps onto plain RAM; a reset must leave its contents intact.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= wr_data;
  end

  // A write landing on the same edge as the first fetch is forwarded so the frame includes it.
  assign rd_addr = row_d * AW'(COLS) + col_d;
  assign rd_data = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
  assign conv_d  = fetch ? rd_data : conv_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    load_d  = load_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fetch   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b1;
          load_d  = 1'b1;
          busy_d  = 1'b1;
          fetch   = 1'b1;
        end
      end
      S_STREAM: begin
        if (col_q != AW'(COLS - 1)) begin
          col_d   = col_q + AW'(1);
          valid_d = 1'b1;
          fetch   = 1'b1;
        end else if (row_q == AW'(ROWS - 1)) begin
          state_d = S_TAIL;
        end else if (GAP == 0) begin
          row_d   = row_q + AW'(1);
          col_d   = '0;
          valid_d = 1'b1;
          fetch   = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP - 1)) begin
          state_d = S_STREAM;
          row_d   = row_q + AW'(1);
          col_d   = '0;
          valid_d = 1'b1;
          fetch   = 1'b1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_TAIL: begin
        state_d = S_IDLE;
        load_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      gap_q   <= '0;
      conv_q  <= '0;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      conv_q  <= conv_d;
      valid_q <= valid_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign load      = load_q;
  assign conv_out  = conv_q;
  assign out_valid = valid_q;
  assign row_idx   = row_q;
  assign col_idx   = col_q;
  assign done      = done_q;

endmodule
